// File: rtl/prod_accumulator.sv
// Streaming accumulator behind the Dadda multiplier: sums a programmed number of
// unsigned products and returns the total with a sticky carry-out flag.
module prod_accumulator #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 40,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic              clr,
  input  logic              prod_valid,
  input  logic [DATA_W-1:0] prod_data,
  output logic              prod_ready,
  output logic              res_valid,
  output logic [ACC_W-1:0]  res_data,
  output logic              res_ovf,
  input  logic              res_ready,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [ACC_W-1:0]   r_acc;
  logic               r_ovf;
  logic [CNT_W-1:0]   r_rem;

  state_t             w_state_next;
  logic [ACC_W-1:0]   w_acc_next;
  logic               w_ovf_next;
  logic [CNT_W-1:0]   w_rem_next;
  logic               w_take_start;
  logic [ACC_W:0]     w_sum;

  // One extra bit on the adder captures the carry out of the accumulator.
  assign w_sum = {1'b0, r_acc} + {{(ACC_W + 1 - DATA_W){1'b0}}, prod_data};

  always_comb begin
    w_state_next = r_state;
    w_acc_next   = r_acc;
    w_ovf_next   = r_ovf;
    w_rem_next   = r_rem;
    w_take_start = 1'b0;
    if (clr) begin
      w_state_next = S_IDLE;
      w_acc_next   = '0;
      w_ovf_next   = 1'b0;
      w_rem_next   = '0;
    end else begin
      case (r_state)
        S_IDLE: w_take_start = start;
        S_ACC: begin
          if (prod_valid) begin
            w_acc_next = w_sum[ACC_W-1:0];
            w_ovf_next = r_ovf | w_sum[ACC_W];
            w_rem_next = r_rem - 1'b1;
            if (r_rem == CNT_W'(1)) w_state_next = S_DONE;
          end
        end
        S_DONE: begin
          if (res_ready) begin
            w_state_next = S_IDLE;
            w_take_start = start;
          end
        end
        default: w_state_next = S_IDLE;
      endcase
      // A start seen at a result handshake begins the next run without a bubble.
      if (w_take_start) begin
        w_acc_next   = '0;
        w_ovf_next   = 1'b0;
        w_rem_next   = len;
        w_state_next = (len == '0) ? S_DONE : S_ACC;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_ovf   <= 1'b0;
      r_rem   <= '0;
    end else begin
      r_state <= w_state_next;
      r_acc   <= w_acc_next;
      r_ovf   <= w_ovf_next;
      r_rem   <= w_rem_next;
    end
  end

  assign prod_ready = (r_state == S_ACC);
  assign res_valid  = (r_state == S_DONE);
  assign busy       = (r_state != S_IDLE);
  assign res_data   = r_acc;
  assign res_ovf    = r_ovf;

endmodule

// File: tb/tb_prod_accumulator.sv
// Scoreboard bench for prod_accumulator: expected sums are queued as products are
// driven and popped when the result port presents a value.
module tb_prod_accumulator;
  localparam int DATA_W = 32;
  localparam int ACC_W  = 34;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [CNT_W-1:0]  len = '0;
  logic              clr = 1'b0;
  logic              prod_valid = 1'b0;
  logic [DATA_W-1:0] prod_data = '0;
  logic              prod_ready;
  logic              res_valid;
  logic [ACC_W-1:0]  res_data;
  logic              res_ovf;
  logic              res_ready = 1'b0;
  logic              busy;

  int tests_run = 0;
  int tests_failed = 0;

  logic [ACC_W:0]   sb[$];
  logic [ACC_W-1:0] m_acc;
  logic             m_ovf;

  prod_accumulator #(.DATA_W(DATA_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .clr(clr),
    .prod_valid(prod_valid), .prod_data(prod_data), .prod_ready(prod_ready),
    .res_valid(res_valid), .res_data(res_data), .res_ovf(res_ovf),
    .res_ready(res_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  // Stimulus helpers: each is entered just after a falling edge and leaves on one.
  task automatic start_run(input int n);
    m_acc = '0;
    m_ovf = 1'b0;
    start = 1'b1;
    len   = CNT_W'(n);
    @(negedge clk);
    start = 1'b0;
    len   = '0;
  endtask

  task automatic feed(input logic [DATA_W-1:0] d, input int gap);
    logic [ACC_W:0] t;
    prod_valid = 1'b0;
    repeat (gap) @(negedge clk);
    prod_valid = 1'b1;
    prod_data  = d;
    @(negedge clk);
    prod_valid = 1'b0;
    t = {1'b0, m_acc} + {{(ACC_W + 1 - DATA_W){1'b0}}, d};
    m_acc = t[ACC_W-1:0];
    m_ovf = m_ovf | t[ACC_W];
  endtask

  task automatic wait_res(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (res_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests_run++;
    if ({prod_ready, res_valid, busy, res_ovf, res_data} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got rdy=%0b vld=%0b busy=%0b ovf=%0b data=%0h, want all 0",
               prod_ready, res_valid, busy, res_ovf, res_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release_idle: got busy=%0b vld=%0b, want 0 0", busy, res_valid);
    end
  endtask

  task automatic test_basic();
    logic [ACC_W:0] exp;
    bit ok;
    logic [DATA_W-1:0] vals [4] = '{32'd35, 32'd2, 32'd6, 32'd12};
    start_run(4);
    tests_run++;
    if (prod_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_prod_ready: got %0b, want 1", prod_ready);
    end
    for (int i = 0; i < 4; i++) begin
      if (i == 3) sb.push_back({m_ovf, m_acc} + ACC_W'(vals[3]));
      feed(vals[i], 0);
      if (i == 2) begin
        tests_run++;
        if (res_valid !== 1'b0) begin
          tests_failed++;
          $display("FAIL basic_early_valid: got res_valid=%0b after 3 beats, want 0", res_valid);
        end
      end
    end
    tests_run++;
    if (res_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_latency: got res_valid=%0b one cycle after last beat, want 1", res_valid);
    end
    wait_res(ok);
    exp = sb.pop_front();
    tests_run++;
    if (!ok || {res_ovf, res_data} !== exp || res_data !== ACC_W'(55)) begin
      tests_failed++;
      $display("FAIL basic_result: got ovf=%0b data=%0d, want ovf=%0b data=%0d",
               res_ovf, res_data, exp[ACC_W], exp[ACC_W-1:0]);
    end
    handshake();
    $display("[TB] basic run done: data=%0d", exp[ACC_W-1:0]);
  endtask

  task automatic test_stalls();
    logic [ACC_W:0] exp;
    bit ok;
    start_run(3);
    feed(32'd10, 2);
    start = 1'b1;
    len   = 8'd7;
    feed(32'd20, 2);
    start = 1'b0;
    len   = '0;
    feed(32'd30, 2);
    sb.push_back({m_ovf, m_acc});
    wait_res(ok);
    exp = sb.pop_front();
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (!ok || res_valid !== 1'b1 || prod_ready !== 1'b0 || {res_ovf, res_data} !== exp) begin
        tests_failed++;
        $display("FAIL stall_hold%0d: got vld=%0b rdy=%0b data=%0d, want vld=1 rdy=0 data=%0d",
                 i, res_valid, prod_ready, res_data, exp[ACC_W-1:0]);
      end
      @(negedge clk);
    end
    handshake();
    tests_run++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL stall_idle: got busy=%0b vld=%0b, want 0 0", busy, res_valid);
    end
    $display("[TB] stall run done: data=%0d", exp[ACC_W-1:0]);
  endtask

  task automatic test_zero_len_back_to_back();
    logic [ACC_W:0] exp;
    bit ok;
    start_run(0);
    sb.push_back({m_ovf, m_acc});
    exp = sb.pop_front();
    tests_run++;
    if (res_valid !== 1'b1 || prod_ready !== 1'b0 || {res_ovf, res_data} !== exp) begin
      tests_failed++;
      $display("FAIL zero_len: got vld=%0b rdy=%0b data=%0d, want vld=1 rdy=0 data=0",
               res_valid, prod_ready, res_data);
    end
    m_acc = '0;
    m_ovf = 1'b0;
    res_ready = 1'b1;
    start = 1'b1;
    len = 8'd1;
    @(negedge clk);
    res_ready = 1'b0;
    start = 1'b0;
    len = '0;
    tests_run++;
    if (busy !== 1'b1 || prod_ready !== 1'b1 || res_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL back_to_back_no_bubble: got busy=%0b rdy=%0b vld=%0b, want 1 1 0",
               busy, prod_ready, res_valid);
    end
    feed(32'd9, 0);
    sb.push_back({m_ovf, m_acc});
    wait_res(ok);
    exp = sb.pop_front();
    tests_run++;
    if (!ok || {res_ovf, res_data} !== exp) begin
      tests_failed++;
      $display("FAIL back_to_back_result: got data=%0d, want %0d", res_data, exp[ACC_W-1:0]);
    end
    handshake();
    $display("[TB] zero-length and back-to-back done");
  endtask

  task automatic test_overflow();
    logic [ACC_W:0] exp;
    bit ok;
    start_run(5);
    for (int i = 0; i < 5; i++) feed(32'hFFFF_FFFF, 0);
    sb.push_back({m_ovf, m_acc});
    wait_res(ok);
    exp = sb.pop_front();
    tests_run++;
    if (!ok || {res_ovf, res_data} !== exp || {res_ovf, res_data} !== {1'b1, 34'h0_FFFF_FFFB}) begin
      tests_failed++;
      $display("FAIL overflow_result: got ovf=%0b data=%0h, want ovf=%0b data=%0h",
               res_ovf, res_data, exp[ACC_W], exp[ACC_W-1:0]);
    end
    handshake();
    start_run(1);
    feed(32'd1, 0);
    sb.push_back({m_ovf, m_acc});
    wait_res(ok);
    exp = sb.pop_front();
    tests_run++;
    if (!ok || {res_ovf, res_data} !== exp) begin
      tests_failed++;
      $display("FAIL overflow_cleared: got ovf=%0b data=%0h, want ovf=%0b data=%0h",
               res_ovf, res_data, exp[ACC_W], exp[ACC_W-1:0]);
    end
    handshake();
    $display("[TB] overflow runs done");
  endtask

  task automatic test_abort();
    logic [ACC_W:0] exp;
    bit ok;
    start_run(4);
    feed(32'd1, 0);
    feed(32'd2, 0);
    clr = 1'b1;
    prod_valid = 1'b1;
    prod_data = 32'd5;
    @(negedge clk);
    clr = 1'b0;
    prod_valid = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || prod_ready !== 1'b0 || res_valid !== 1'b0 || res_data !== '0) begin
      tests_failed++;
      $display("FAIL abort_idle: got busy=%0b rdy=%0b vld=%0b data=%0d, want 0 0 0 0",
               busy, prod_ready, res_valid, res_data);
    end
    start_run(1);
    feed(32'd7, 0);
    sb.push_back({m_ovf, m_acc});
    wait_res(ok);
    exp = sb.pop_front();
    tests_run++;
    if (!ok || {res_ovf, res_data} !== exp) begin
      tests_failed++;
      $display("FAIL abort_restart: got data=%0d, want %0d", res_data, exp[ACC_W-1:0]);
    end
    handshake();
    $display("[TB] abort done");
  endtask

  task automatic test_async_reset();
    logic [ACC_W:0] exp;
    bit ok;
    start_run(1);
    feed(32'd4, 0);
    wait_res(ok);
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (!ok || {res_valid, busy, prod_ready, res_ovf, res_data} !== '0) begin
      tests_failed++;
      $display("FAIL async_reset: got vld=%0b busy=%0b ovf=%0b data=%0d, want all 0",
               res_valid, busy, res_ovf, res_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_run(1);
    feed(32'd3, 0);
    sb.push_back({m_ovf, m_acc});
    wait_res(ok);
    exp = sb.pop_front();
    tests_run++;
    if (!ok || {res_ovf, res_data} !== exp) begin
      tests_failed++;
      $display("FAIL async_reset_restart: got data=%0d, want %0d", res_data, exp[ACC_W-1:0]);
    end
    handshake();
    $display("[TB] async reset done");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stalls();
    test_zero_len_back_to_back();
    test_overflow();
    test_abort();
    test_async_reset();
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/prod_accumulator.md
Name: prod_accumulator

Overview:
- Sequential stage directly downstream of the 32-bit Dadda multiplier.
- Consumes a stream of unsigned multiplier products over a valid/ready handshake and sums a programmed number of them into a wide accumulator.
- Presents the final sum, with a sticky overflow flag, on a valid/ready result port.
- Used for dot-product and MAC sequences built on the combinational multiplier.

Parameters:
DATA_W, 32, width of incoming product (matches multiplier prod output)
ACC_W, 40, accumulator/result width; must be >= DATA_W
CNT_W, 8, width of the length field (max products per run = 2^CNT_W - 1)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a run; sampled only when accepted (see Behaviour)
len  input  CNT_W  number of products in the run, sampled with accepted start
clr  input  1  synchronous abort; returns block to IDLE
prod_valid  input  1  upstream product valid
prod_data  input  DATA_W  unsigned product from multiplier
prod_ready  output  1  block accepts a product this cycle
res_valid  output  1  result available
res_data  output  ACC_W  accumulated sum
res_ovf  output  1  sticky: a carry out of ACC_W occurred during the run
res_ready  input  1  downstream accepts result
busy  output  1  high in ACC or DONE

Behaviour:
- One clock and one reset. Reset is asynchronous and active-low: rst_n low immediately forces state=IDLE, acc=0, remaining=0, res_ovf=0. All outputs read 0 while rst_n is low. Works identically when asserted mid-run.
- State IDLE:
  - prod_ready=0, res_valid=0, busy=0.
  - start=1 is accepted: acc<=0, ovf<=0, remaining<=len.
  - Next state: DONE if len==0, else ACC.
- State ACC:
  - prod_ready=1, busy=1.
  - Each cycle with prod_valid&&prod_ready: acc<=(acc+zero_extend(prod_data)) mod 2^ACC_W.
  - On that beat, ovf<=ovf | carry_out, and remaining<=remaining-1.
  - The accepting beat with remaining==1 moves to DONE.
  - Cycles with prod_valid=0 leave all state unchanged.
- State DONE:
  - res_valid=1, prod_ready=0, busy=1.
  - res_data=acc and res_ovf=ovf, both held stable until handshake.
  - res_valid&&res_ready moves to IDLE.
  - If start=1 in the same cycle as the handshake, start is accepted as from IDLE (back-to-back run, no bubble).
- start is ignored in ACC, and ignored in DONE without a same-cycle handshake.
- clr=1:
  - Next state IDLE from any state; acc, remaining and ovf are cleared.
  - Any pending result is discarded; no handshake is required.
  - clr has priority over start, prod and res handshakes in the same cycle. A product offered that cycle is not accepted (prod_ready is still 1 combinationally in ACC, but the beat is discarded). Upstream must treat clr as a flush.
- Latency:
  - res_valid rises the cycle after the last product is accepted.
  - For len==0, res_valid rises the cycle after start, with res_data=0.
- Arithmetic: unsigned only, no saturation, wraps modulo 2^ACC_W.
  - At the defaults, overflow is impossible: (2^8-1)*(2^32-1) < 2^40.
  - res_ovf is meaningful for narrower ACC_W.
- res_data/res_ovf outside DONE: hold last acc/ovf value (don't-care to consumers; cleared by reset/clr/start).
- prod_ready and res_valid are decoded from registered state only; no combinational path from prod_valid/res_ready to them.

Test Plan:
- Basic run: start with len=4; products 35,2,6,12 (5*7,1*2,2*3,3*4) offered back-to-back -> four accepts; res_valid high one cycle after the 4th accept; res_data=55, res_ovf=0.
- Stalls: len=3 with prod_valid gaps of 2 cycles (values 10,20,30), then res_ready low 3 cycles -> acc unaffected by gaps; res_data=60 stable and prod_ready=0 throughout DONE; IDLE after res_ready.
- Zero length: start with len=0 -> no prod_ready; res_valid next cycle with res_data=0. A start alongside res_ready with len=1 and product 9 -> next result 9, no idle cycle.
- Overflow: ACC_W=34, len=5, all products 0xFFFFFFFF -> res_data=0x0FFFFFFFB, res_ovf=1. A following run with len=1 and product 1 -> res_data=1, res_ovf=0.
- Abort: len=4; clr after 2 accepted products, with prod_valid=1 -> IDLE, busy=0, prod_ready=0; start with len=1 and product 7 -> res_data=7.
- Async reset: rst_n low mid-DONE (not clock-aligned) -> res_valid, busy, res_data and res_ovf go 0 immediately. After release, start with len=1 and product 3 -> res_data=3.
